// File: rtl/dummy_wire_ks_pkg.sv
// Shared types and helpers for the dummy-wire key search controller:
// FSM state enum, default LFSR polynomial, LFSR step, lowest-set-bit encoder.
package dummy_wire_ks_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_CHECK,
    S_NEXT_KEY,
    S_DONE
  } ks_state_e;

  // Right-shift Galois mask for taps 36,25
  localparam logic [35:0] DW_POLY_36 = 36'h8_0100_0000;

  function automatic logic [63:0] lfsr_next(
    input logic [63:0] s,
    input logic [63:0] poly
  );
    return (s >> 1) ^ (s[0] ? poly : 64'd0);
  endfunction

  function automatic logic [7:0] lowest_set(
    input logic [255:0] m
  );
    logic [7:0] idx;
    idx = '0;
    for (int i = 255; i >= 0; i--) begin
      if (m[i]) idx = 8'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dummy_wire_ks_lfsr.sv
// Galois pattern LFSR for the key search: reseed on load, step on adv.
// Reset and load both restore SEED so every key sees the same sequence.
module dummy_wire_ks_lfsr
  import dummy_wire_ks_pkg::*;
#(
  parameter int              PI_W = 36,
  parameter logic [PI_W-1:0] POLY = PI_W'(DW_POLY_36),
  parameter logic [PI_W-1:0] SEED = PI_W'(1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            adv,
  output logic [PI_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else if (adv) begin
      q <= PI_W'(lfsr_next(64'(q), 64'(POLY)));
    end
  end

endmodule

// File: rtl/dummy_wire_key_search.sv
// Oracle-guided brute-force key sweep over a locked combinational netlist.
// Build option DUMMY_WIRE_KS_EARLY_ABORT_EN skips a key's patterns on first mismatch.
module dummy_wire_key_search
  import dummy_wire_ks_pkg::*;
#(
  parameter int              KEY_W  = 2,
  parameter int              PI_W   = 36,
  parameter int              PO_W   = 7,
  parameter int              PAT_N  = 16,
  parameter int              SETTLE = 2,
  parameter logic [PI_W-1:0] SEED   = PI_W'(1),
  parameter logic [PI_W-1:0] POLY   = PI_W'(DW_POLY_36)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [KEY_W-1:0]    key_drive,
  output logic [PI_W-1:0]     pi_out,
  input  logic [PO_W-1:0]     locked_po,
  input  logic [PO_W-1:0]     oracle_po,
  output logic                busy,
  output logic                done,
  output logic [2**KEY_W-1:0] cand_mask,
  output logic                found,
  output logic                unique_hit,
  output logic [KEY_W-1:0]    key_out
);

  localparam int CW = 2**KEY_W;
  localparam int SW = $clog2(SETTLE + 1);

  ks_state_e        state;
  logic [KEY_W-1:0] kcnt;
  logic [15:0]      pcnt;
  logic [SW-1:0]    scnt;
  logic             key_fail;
  logic             mism;
  logic             last_pat;
  logic             any_hit;
  logic             one_hit;
  logic [PI_W-1:0]  lfsr_q;
  logic [PI_W-1:0]  lfsr_nx;

  assign mism    = locked_po != oracle_po;
  assign lfsr_nx = PI_W'(lfsr_next(64'(lfsr_q), 64'(POLY)));
  assign any_hit = |cand_mask;
  assign one_hit = any_hit && ((cand_mask & (cand_mask - CW'(1))) == '0);

`ifdef DUMMY_WIRE_KS_EARLY_ABORT_EN
  assign last_pat = (pcnt == 16'(PAT_N - 1)) || mism;
`else
  assign last_pat = (pcnt == 16'(PAT_N - 1));
`endif

  dummy_wire_ks_lfsr #(
    .PI_W (PI_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == S_LOAD),
    .adv   (state == S_CHECK),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      kcnt       <= '0;
      pcnt       <= '0;
      scnt       <= '0;
      key_fail   <= 1'b0;
      key_drive  <= '0;
      pi_out     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cand_mask  <= '0;
      found      <= 1'b0;
      unique_hit <= 1'b0;
      key_out    <= '0;
    end else if (abort && state != S_IDLE) begin
      // key_drive and pi_out deliberately hold
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cand_mask  <= '0;
      found      <= 1'b0;
      unique_hit <= 1'b0;
      key_out    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            cand_mask  <= '0;
            found      <= 1'b0;
            unique_hit <= 1'b0;
            key_out    <= '0;
            kcnt       <= '0;
            busy       <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          key_drive <= kcnt;
          pi_out    <= SEED;
          pcnt      <= '0;
          scnt      <= '0;
          key_fail  <= 1'b0;
          state     <= S_APPLY;
        end
        S_APPLY: begin
          if (scnt == SW'(SETTLE - 1)) state <= S_CHECK;
          else scnt <= scnt + SW'(1);
        end
        S_CHECK: begin
          key_fail <= key_fail | mism;
          scnt     <= '0;
          if (last_pat) begin
            state <= S_NEXT_KEY;
          end else begin
            pcnt   <= pcnt + 16'd1;
            pi_out <= lfsr_nx;
            state  <= S_APPLY;
          end
        end
        S_NEXT_KEY: begin
          cand_mask[kcnt] <= ~key_fail;
          if (kcnt == {KEY_W{1'b1}}) begin
            state <= S_DONE;
          end else begin
            kcnt  <= kcnt + KEY_W'(1);
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          found      <= any_hit;
          unique_hit <= one_hit;
          key_out    <= KEY_W'(lowest_set(256'(cand_mask)));
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dummy_wire_key_search.sv
// Directed bench for dummy_wire_key_search with a behavioural locked/oracle pair.
// Honours DUMMY_WIRE_KS_EARLY_ABORT_EN for the expected sweep latencies.
module tb_dummy_wire_key_search;

  localparam int KEY_W = 2;
  localparam int PI_W  = 36;
  localparam int PO_W  = 7;

`ifdef DUMMY_WIRE_KS_EARLY_ABORT_EN
  localparam int LAT1 = 67;
  localparam int LAT2 = 112;
  localparam int LAT3 = 22;
`else
  localparam int LAT1 = 202;
  localparam int LAT2 = 202;
  localparam int LAT3 = 202;
`endif

  localparam logic [35:0] PAT0 = 36'h0_0000_0001;
  localparam logic [35:0] PAT1 = 36'h8_0100_0000;
  localparam logic [35:0] PAT2 = 36'h4_0080_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [KEY_W-1:0] key_drive;
  logic [PI_W-1:0]  pi_out;
  logic [PO_W-1:0]  locked_po;
  logic [PO_W-1:0]  oracle_po;
  logic             busy;
  logic             done;
  logic [3:0]       cand_mask;
  logic             found;
  logic             unique_hit;
  logic [KEY_W-1:0] key_out;
  logic [3:0]       good_mask = 4'b0100;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  bit seen_done;

  always #5 clk = ~clk;

  assign oracle_po = pi_out[6:0] ^ pi_out[35:29];
  assign locked_po = good_mask[key_drive] ? oracle_po
                   : oracle_po ^ {6'b0, pi_out[0]};

  dummy_wire_key_search dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .key_drive  (key_drive),
    .pi_out     (pi_out),
    .locked_po  (locked_po),
    .oracle_po  (oracle_po),
    .busy       (busy),
    .done       (done),
    .cand_mask  (cand_mask),
    .found      (found),
    .unique_hit (unique_hit),
    .key_out    (key_out)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Start a sweep, poke start again mid-run, wait (bounded) for done
  task automatic sweep(input string tag, input int lat);
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    do begin
      step();
      if (cyc == 1) check({tag, "_busy_rise"}, busy, 1);
      if (cyc == 20) start = 1'b1;
    end while (!done && cyc < 400);
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_fall"}, busy, 0);
  endtask

  task automatic results(input string tag, input logic [3:0] m,
                         input logic f, input logic u,
                         input logic [KEY_W-1:0] k);
    check({tag, "_mask"}, cand_mask, m);
    check({tag, "_found"}, found, f);
    check({tag, "_unique"}, unique_hit, u);
    check({tag, "_key_out"}, key_out, k);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pi", pi_out, 0);
    check("rst_key_drive", key_drive, 0);
    results("rst", 4'b0000, 0, 0, 0);
    rst_n = 1'b1;

    good_mask = 4'b0100;
    sweep("s1", LAT1);
    results("s1", 4'b0100, 1, 1, 2);
    cyc = 0;
    step();
    check("s1_done_pulse", done, 0);

    start = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_start_abort_busy", busy, 0);
    results("idle_hold", 4'b0100, 1, 1, 2);
    repeat (3) step();
    check("idle_start_abort_stay", busy, 0);

    good_mask = 4'b1010;
    sweep("s2", LAT2);
    results("s2", 4'b1010, 1, 0, 1);

    good_mask = 4'b0000;
    sweep("s3", LAT3);
    results("s3", 4'b0000, 0, 0, 0);

    good_mask = 4'b1111;
    seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    repeat (60) begin
      step();
      if (cyc == 2) check("pi_seed", pi_out, PAT0);
      if (cyc == 5) check("pi_adv1", pi_out, PAT1);
      if (done) seen_done = 1'b1;
    end
    check("ab_mask_pre", cand_mask, 4'b0001);
    check("ab_key_pre", key_drive, 1);
    check("ab_pi_pre", pi_out, PAT2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_mask", cand_mask, 0);
    check("ab_key_hold", key_drive, 1);
    check("ab_pi_hold", pi_out, PAT2);
    repeat (250) begin
      step();
      if (done) seen_done = 1'b1;
    end
    check("ab_no_done", seen_done, 0);
    check("ab_idle", busy, 0);

    good_mask = 4'b0100;
    sweep("s4", LAT1);
    results("s4", 4'b0100, 1, 1, 2);

    good_mask = 4'b1111;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    repeat (9) step();
    check("rs_pi_pre", pi_out, PAT2);
    check("rs_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_busy", busy, 0);
    check("rs_pi", pi_out, 0);
    check("rs_key_drive", key_drive, 0);
    check("rs_done", done, 0);
    results("rs", 4'b0000, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    check("rs_idle", busy, 0);

    good_mask = 4'b0100;
    sweep("s5", LAT1);
    results("s5", 4'b0100, 1, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dummy_wire_key_search.md
# dummy_wire_key_search

Oracle-guided brute-force key recovery controller for the key-locked combinational netlists produced by our dummy-wire locking flow. It drives a shared primary-input pattern into both a locked netlist and its unlocked oracle, and sweeps every candidate value on the locked netlist's key inputs. For each key it compares the two output vectors over a repeatable pseudo-random pattern sequence and reports which keys survive. It sits in the deobfuscation test harness between the pattern source and the pair of combinational netlist instances.

## Interface
Parameters:
- KEY_W, 2, width of the key bus driving the locked netlist's D_* inputs; 1..8
- PI_W, 36, primary-input width
- PO_W, 7, primary-output width
- PAT_N, 16, patterns applied per key; 1..65535
- SETTLE, 2, cycles the pattern is held before compare; must be ≥1
- SEED, PI_W'h1, LFSR seed; must be nonzero

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a sweep; ignored while busy
- abort  in  1  synchronous cancel of a running sweep
- key_drive  out  KEY_W  key applied to the locked netlist
- pi_out  out  PI_W  pattern applied to both netlists
- locked_po  in  PO_W  locked-netlist response
- oracle_po  in  PO_W  oracle response
- busy  out  1  high from the cycle after start through the cycle before done
- done  out  1  one-cycle pulse when the sweep completes; not pulsed on abort
- cand_mask  out  2**KEY_W  bit k set means key k matched on all patterns
- found  out  1  cand_mask nonzero
- unique  out  1  exactly one bit of cand_mask set
- key_out  out  KEY_W  lowest surviving key; 0 if none

## Operation
- FSM states: IDLE, LOAD, APPLY, CHECK, NEXT_KEY, DONE.
- IDLE → LOAD on start:
  - clear cand_mask, found, unique, key_out, key counter.
- LOAD (1 cycle):
  - key_drive ← key counter.
  - LFSR ← SEED.
  - pattern counter ← 0.
  - key-fail flag ← 0.
- APPLY:
  - pi_out ← LFSR on entry.
  - hold for SETTLE cycles, then go to CHECK.
- CHECK (1 cycle):
  - If locked_po ≠ oracle_po, set key-fail.
  - Advance the LFSR.
  - If pattern counter = PAT_N−1, go to NEXT_KEY; otherwise increment and go to APPLY.
- NEXT_KEY (1 cycle):
  - cand_mask[key] ← ~key-fail.
  - If key counter = 2**KEY_W−1, go to DONE; otherwise increment and go to LOAD.
- DONE (1 cycle):
  - Register found, unique, and key_out (priority encoder, lowest index) from cand_mask.
  - Pulse done; go to IDLE.
- Every key sees an identical pattern sequence because the LFSR is reseeded in each LOAD.
- LFSR is a Galois LFSR, right shift, XOR with POLY when the LSB is 1.
- Counters are wide enough to hold their terminal values without wrap. The key counter at maximum KEY_W=8 counts 0..255.
- abort in any non-IDLE state:
  - Next state is IDLE.
  - cand_mask and result flags cleared.
  - key_drive and pi_out hold their values.
- abort takes priority over start and over state transitions.
- start and abort in the same IDLE cycle: stay in IDLE.
- Results hold in IDLE until the next accepted start.

## Timing
- Reset values: every output is 0. FSM in IDLE, LFSR = SEED.
- Input compare happens in CHECK, exactly SETTLE+1 cycles after pi_out changes. The netlists are combinational and must settle within SETTLE cycles.
- Per-key cycles, without early abort: 1 + PAT_N·(SETTLE+1) + 1.
- Total latency from start to done: 2**KEY_W·(PAT_N·(SETTLE+1)+2) + 2 cycles.
  - Defaults: 4·(16·3+2)+2 = 202.
- busy rises the cycle after start is accepted. busy falls in the same cycle done rises.
- Outputs are registered; there is no combinational input-to-output path.

## Configuration
- DUMMY_WIRE_KS_EARLY_ABORT_EN
  - Defined: a mismatch in CHECK jumps directly to NEXT_KEY, skipping the remaining patterns for that key. Runtime then depends on the data.
  - Undefined: all PAT_N patterns run for every key. Runtime is the constant given under Timing.
- Final cand_mask is identical in both builds.

## Structure
- Package dummy_wire_ks_pkg holds:
  - the FSM state enum
  - the default POLY constant for PI_W=36 (taps 36,25)
  - the lfsr_next function
  - the lowest-set-bit function used for key_out.
- Sub-module dummy_wire_ks_lfsr: seed load, advance enable, parameterised PI_W and POLY.
- Everything else is in the top-level FSM.

## Test plan
- Defaults. Bench locked model equals the oracle iff key=2'b10; otherwise it inverts PO[0] whenever pi[0]=1.
  - → after 202 cycles: done pulses, cand_mask=4'b0100, found=1, unique=1, key_out=2.
- Locked model equals the oracle for keys 1 and 3.
  - → cand_mask=4'b1010, found=1, unique=0, key_out=1.
- Locked model never matches.
  - → cand_mask=0, found=0, unique=0, key_out=0, done pulses.
- abort asserted on cycle 60 after start.
  - → busy=0 on cycle 61, no done pulse, cand_mask=0.
  - A new start then completes normally in 202 cycles.
- rst_n pulled low mid-APPLY.
  - → all outputs 0 immediately, asynchronously; FSM idle after release.
- With DUMMY_WIRE_KS_EARLY_ABORT_EN and the first scenario's model:
  - cand_mask is identical.
  - Total latency is below 202.
  - start asserted while busy is ignored.
